// File: rtl/pc_tx_scheduler.sv
// pc_tx_scheduler
// Round-robin arbiter feeding 32-bit words from two sources (A, B) into the
// PC_TX serialiser/UART. One word is issued at a time as a one-cycle
// next-word command. Word completion is detected from the UART tx-active
// flag: once it has been low for IDLE_GAP_CLKS consecutive cycles the word
// is finished. If the flag never rises within START_TIMEOUT_CLKS cycles of
// a command, o_timeout pulses and the word is dropped (no retry).
//
// Optional build macro: PC_TX_SCHED_HDR_EN
//   When defined, every grant sends a header word {16'hA55A, 15'h0, src}
//   (src 0 = A, 1 = B) before the payload. The header has the same start
//   timeout and completion rules as the payload. A header timeout drops
//   the payload.
//
// Ports
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_req_a / i_word_a      source A request and word
//   i_req_b / i_word_b      source B request and word
//   o_grant_a / o_grant_b   one-cycle pulse: that source's word was taken
//   i_tx_busy               tx-active flag from PC_TX
//   o_tx_word               word presented to PC_TX
//   o_tx_next_word_cmd      one-cycle command to PC_TX
//   o_sched_busy            high whenever the FSM is not in IDLE
//   o_timeout               one-cycle pulse on start timeout
//   o_dbg_state             current FSM state encoding, for observation
//
// Handshake: a source raises i_req_x with i_word_x stable and holds both
// until it sees o_grant_x. The grant is a one-cycle acknowledge that the
// word was captured; from the next cycle the source either drops i_req_x
// or presents its next word. A request still high then is a new word.

module pc_tx_scheduler #(
  parameter int IDLE_GAP_CLKS      = 16,
  parameter int START_TIMEOUT_CLKS = 64,
  parameter int CNT_W              = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_a,
  input  logic [31:0] i_word_a,
  input  logic        i_req_b,
  input  logic [31:0] i_word_b,
  output logic        o_grant_a,
  output logic        o_grant_b,
  input  logic        i_tx_busy,
  output logic [31:0] o_tx_word,
  output logic        o_tx_next_word_cmd,
  output logic        o_sched_busy,
  output logic        o_timeout,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    WAIT_DONE  = 3'd2,
    HDR_START  = 3'd3,
    HDR_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP_CLKS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_b_q, prio_b_d;   // 1: B wins a tie
  logic              grant_a_q, grant_a_d;
  logic              grant_b_q, grant_b_d;
  logic [31:0]       word_q, word_d;
  logic              cmd_q, cmd_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              pick_b;
`ifdef PC_TX_SCHED_HDR_EN
  logic [31:0]       payload_q, payload_d;
`endif

  // B wins when it is the only requester, or on a tie when it was not
  // granted last.
  assign pick_b = i_req_b & (~i_req_a | prio_b_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_b_d  = prio_b_q;
    word_d    = word_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    cmd_d     = 1'b0;
    timeout_d = 1'b0;
`ifdef PC_TX_SCHED_HDR_EN
    payload_d = payload_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_a | i_req_b) begin
          grant_a_d = ~pick_b;
          grant_b_d = pick_b;
          prio_b_d  = ~pick_b;
          cmd_d     = 1'b1;
          cnt_d     = '0;
`ifdef PC_TX_SCHED_HDR_EN
          word_d    = {16'hA55A, 15'h0, pick_b};
          payload_d = pick_b ? i_word_b : i_word_a;
          state_d   = HDR_START;
`else
          word_d    = pick_b ? i_word_b : i_word_a;
          state_d   = WAIT_START;
`endif
        end
      end
      WAIT_START: begin
        if (i_tx_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q == START_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        // The flag drops briefly between bytes; only a full quiet window
        // means the last byte has gone out.
        if (i_tx_busy) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PC_TX_SCHED_HDR_EN
      HDR_START: begin
        if (i_tx_busy) begin
          cnt_d   = '0;
          state_d = HDR_DONE;
        end else if (cnt_q == START_LAST) begin
          // Header never started: the payload is abandoned.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HDR_DONE: begin
        if (i_tx_busy) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          // Header finished: issue the latched payload straight away.
          word_d  = payload_q;
          cmd_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_b_q  <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      word_q    <= 32'h0;
      cmd_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PC_TX_SCHED_HDR_EN
      payload_q <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_b_q  <= prio_b_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      word_q    <= word_d;
      cmd_q     <= cmd_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
`ifdef PC_TX_SCHED_HDR_EN
      payload_q <= payload_d;
`endif
    end
  end

  assign o_grant_a          = grant_a_q;
  assign o_grant_b          = grant_b_q;
  assign o_tx_word          = word_q;
  assign o_tx_next_word_cmd = cmd_q;
  assign o_sched_busy       = busy_q;
  assign o_timeout          = timeout_q;
  assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_pc_tx_scheduler.sv
// Bench for pc_tx_scheduler. Cycle k is the k-th falling clock edge; inputs
// driven at edge k are sampled on the next rising edge and their effect is
// visible at edge k+1. The UART is modelled by a busy schedule the bench
// chooses for each command (start delay, four byte bursts with short gaps,
// or never starting), from which the bench derives when the scheduler must
// be free again, when timeouts must pulse and which word must go next.

module tb_pc_tx_scheduler;

  localparam int GAP  = 16;
  localparam int TO   = 64;
  localparam int MAXC = 20000;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_a, i_req_b, i_tx_busy;
  logic [31:0] i_word_a, i_word_b;
  logic        o_grant_a, o_grant_b, o_tx_next_word_cmd, o_sched_busy, o_timeout;
  logic [31:0] o_tx_word;
  logic [2:0]  o_dbg_state;

  always #10 clk = ~clk;

  pc_tx_scheduler #(
    .IDLE_GAP_CLKS(GAP),
    .START_TIMEOUT_CLKS(TO),
    .CNT_W(8)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_req_a(i_req_a),
    .i_word_a(i_word_a),
    .i_req_b(i_req_b),
    .i_word_b(i_word_b),
    .o_grant_a(o_grant_a),
    .o_grant_b(o_grant_b),
    .i_tx_busy(i_tx_busy),
    .o_tx_word(o_tx_word),
    .o_tx_next_word_cmd(o_tx_next_word_cmd),
    .o_sched_busy(o_sched_busy),
    .o_timeout(o_timeout),
    .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // Stimulus sources and scoreboard.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_q[$];
  bit          busy_plan[MAXC];

  int          ready_k;      // first cycle whose inputs the scheduler samples in IDLE
  int          to_k;         // cycle at which o_timeout must be seen
  int          hdr_pay_k;    // cycle at which the payload command must follow a header
  int          cur_s;        // first busy cycle of the most recent plan
  int          last_src;     // -1 none, 0 A, 1 B
  int          cmd_cnt;
  int          words_added;
  logic [31:0] exp_word;
  logic [31:0] pay_word;
  logic        prev_req_a, prev_req_b;

  // Fill the busy schedule for a command seen at cycle c. h returns the
  // last busy cycle, or -1 if the UART never starts.
  task automatic plan_word(input int c, input bit stuck, output int h);
    int t;
    int len;
    if (stuck) begin
      h = -1;
    end else begin
      t = c + int'($urandom_range(0, 4));
      cur_s = t;
      for (int b = 0; b < 4; b++) begin
        len = int'($urandom_range(2, 8));
        for (int j = 0; j < len; j++) if (t + j < MAXC) busy_plan[t + j] = 1'b1;
        t += len;
        if (b < 3) t += int'($urandom_range(1, 5));
      end
      h = t - 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant_a"}, o_grant_a, 0);
    check({tag, "_grant_b"}, o_grant_b, 0);
    check({tag, "_cmd"}, o_tx_next_word_cmd, 0);
    check({tag, "_timeout"}, o_timeout, 0);
    check({tag, "_sched_busy"}, o_sched_busy, 0);
    check({tag, "_tx_word"}, o_tx_word, 32'h0);
  endtask

  initial begin
    int          src;
    int          h;
    int          add_hold;
    logic [31:0] w;
    bit          stuck, is_hdr, done, mid_done;
    bit          exp_cmd, exp_ga, exp_gb;

    for (int j = 0; j < MAXC; j++) busy_plan[j] = 1'b0;
    qa.push_back(32'hDEADBEEF);
    for (int j = 0; j < 4; j++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
    end
    i_reset   = 1'b1;
    i_tx_busy = 1'b0;
    i_req_a   = 1'b1;
    i_word_a  = qa[0];
    i_req_b   = 1'b1;
    i_word_b  = qb[0];
    k = -1; ready_k = 0; to_k = -1; hdr_pay_k = -1; cur_s = -100;
    last_src = -1; cmd_cnt = 0; words_added = 0; exp_word = 32'h0; pay_word = 32'h0;
    done = 1'b0; mid_done = 1'b0; add_hold = 40;

    // Reset held with both requests pending: everything quiet.
    repeat (3) begin
      @(negedge clk);
      k++;
    end
    check_all_zero("reset");
    @(negedge clk);
    k++;
    i_reset    = 1'b0;
    ready_k    = k;
    prev_req_a = i_req_a;
    prev_req_b = i_req_b;

    while (!done) begin
      @(negedge clk);
      k++;

      // Reference model: what must appear at this cycle.
      exp_cmd = 1'b0; exp_ga = 1'b0; exp_gb = 1'b0; is_hdr = 1'b0;
      if (hdr_pay_k >= 0 && k == hdr_pay_k) begin
        exp_cmd   = 1'b1;
        exp_word  = pay_word;
        hdr_pay_k = -1;
      end else if (k - 1 >= ready_k && (prev_req_a || prev_req_b)) begin
        if (prev_req_a && prev_req_b) src = (last_src == 0) ? 1 : 0;
        else                          src = prev_req_b ? 1 : 0;
        last_src = src;
        exp_ga   = (src == 0);
        exp_gb   = (src == 1);
        if (src == 0) w = qa.pop_front();
        else          w = qb.pop_front();
`ifdef PC_TX_SCHED_HDR_EN
        exp_word = {16'hA55A, 15'h0, src[0]};
        pay_word = w;
        is_hdr   = 1'b1;
`else
        exp_word = w;
`endif
        exp_cmd = 1'b1;
      end
      if (exp_cmd) begin
        exp_q.push_back(exp_word);
        cmd_cnt++;
        if (cmd_cnt == 3)       stuck = 1'b1;
        else if (cmd_cnt == 12) stuck = 1'b0;
        else                    stuck = ($urandom_range(0, 5) == 0);
        plan_word(k, stuck, h);
        if (stuck) begin
          to_k    = k + TO;
          ready_k = k + TO;
        end else if (is_hdr) begin
          hdr_pay_k = h + GAP + 1;
          ready_k   = MAXC * 4;
        end else begin
          ready_k = h + GAP + 1;
        end
      end

      check("cmd", o_tx_next_word_cmd, exp_cmd);
      check("grant_a", o_grant_a, exp_ga);
      check("grant_b", o_grant_b, exp_gb);
      check("timeout", o_timeout, (k == to_k));
      check("sched_busy", o_sched_busy, (k < ready_k));
      check("tx_word", o_tx_word, exp_word);
      if (o_tx_next_word_cmd) begin
        if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
        else                   check("cmd_word", o_tx_word, exp_q.pop_front());
      end

      // Reset in the middle of a word's transmission (busy already seen).
      if (!mid_done && cmd_cnt == 12 && k == cur_s + 2) begin
        mid_done  = 1'b1;
        i_reset   = 1'b1;
        #1;
        check_all_zero("mid_reset");
        qa.delete(); qb.delete(); exp_q.delete();
        for (int j = k; j < MAXC; j++) busy_plan[j] = 1'b0;
        last_src = -1; hdr_pay_k = -1; to_k = -1; exp_word = 32'h0;
        i_req_a = 1'b0; i_req_b = 1'b0; i_tx_busy = 1'b0;
        repeat (2) begin
          @(negedge clk);
          k++;
        end
        i_reset    = 1'b0;
        ready_k    = k;
        prev_req_a = 1'b0;
        prev_req_b = 1'b0;
        add_hold   = k + 20;
        continue;
      end

      // New words arrive at random times.
      if (k >= add_hold && words_added < 60 && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) qa.push_back($urandom);
        else                           qb.push_back($urandom);
        words_added++;
      end

      i_tx_busy  = busy_plan[k];
      i_req_a    = (qa.size() > 0);
      i_word_a   = (qa.size() > 0) ? qa[0] : 32'h0;
      i_req_b    = (qb.size() > 0);
      i_word_b   = (qb.size() > 0) ? qb[0] : 32'h0;
      prev_req_a = i_req_a;
      prev_req_b = i_req_b;

      if (words_added >= 60 && qa.size() == 0 && qb.size() == 0 && hdr_pay_k < 0 &&
          k > ready_k + 2 && k > to_k + 2) begin
        done = 1'b1;
      end else if (k >= MAXC - 100) begin
        check("run_bound", 1, 0);
        done = 1'b1;
      end
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
